// File: rtl/esm_tune_sequencer.sv
// esm_tune_sequencer
//   Sequences an AD9361 fast-lock profile change: apply the profile, wait
//   for the PLL to be sampled, wait for lock (with timeout), let the PLL
//   settle, then report completion.
//
// Ports
//   Clk                 sole clock
//   Rst                 synchronous active-high reset
//   Tune_req_valid      request present
//   Tune_req_ready      registered; high only while idle
//   Tune_req_profile    fast-lock profile index to apply
//   Tune_req_skip       [0] skip pre-lock wait, [1] skip lock check,
//                       [2] skip post-lock wait
//   Ad9361_control      [2:0] profile, [3] fast-lock enable
//   Ad9361_status       asynchronous AD9361 status, bit 1 = PLL lock
//   Tune_done           one-cycle pulse on successful completion
//   Tune_timeout        one-cycle pulse when the lock wait expires
//   Busy                high whenever the sequencer is not idle
//   Timeout_count       saturating number of timeouts since reset
module esm_tune_sequencer #(
    parameter int PLL_PRE_LOCK_DELAY_CYCLES  = 8,
    parameter int PLL_POST_LOCK_DELAY_CYCLES = 10,
    parameter int LOCK_TIMEOUT_CYCLES        = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Tune_req_valid,
    output logic        Tune_req_ready,
    input  logic [2:0]  Tune_req_profile,
    input  logic [2:0]  Tune_req_skip,
    output logic [3:0]  Ad9361_control,
    input  logic [7:0]  Ad9361_status,
    output logic        Tune_done,
    output logic        Tune_timeout,
    output logic        Busy,
    output logic [15:0] Timeout_count
);

    // One counter serves every timed phase; it only has to reach the
    // largest phase length minus one.
    localparam int MAX_A = (PLL_PRE_LOCK_DELAY_CYCLES > PLL_POST_LOCK_DELAY_CYCLES) ?
                           PLL_PRE_LOCK_DELAY_CYCLES : PLL_POST_LOCK_DELAY_CYCLES;
    localparam int MAX_C = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W = (MAX_C < 2) ? 1 : $clog2(MAX_C);

    localparam logic [CNT_W-1:0] PRE_LAST  =
        CNT_W'((PLL_PRE_LOCK_DELAY_CYCLES  > 0) ? PLL_PRE_LOCK_DELAY_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] POST_LAST =
        CNT_W'((PLL_POST_LOCK_DELAY_CYCLES > 0) ? PLL_POST_LOCK_DELAY_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST   =
        CNT_W'((LOCK_TIMEOUT_CYCLES        > 0) ? LOCK_TIMEOUT_CYCLES        - 1 : 0);

    localparam bit PRE_ZERO  = (PLL_PRE_LOCK_DELAY_CYCLES  == 0);
    localparam bit POST_ZERO = (PLL_POST_LOCK_DELAY_CYCLES == 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        APPLY     = 3'd1,
        PRELOCK   = 3'd2,
        LOCK_WAIT = 3'd3,
        POSTLOCK  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       lock_sync;
    logic             lock_s;
    logic [2:0]       skip_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             done_nxt;
    logic             to_nxt;

    // Only the lock bit is consumed; the rest of the status bus is ignored.
    logic unused_status;
    assign unused_status = ^{Ad9361_status[7:2], Ad9361_status[0]};

    assign lock_s = lock_sync[1];
    assign accept = Tune_req_valid && Tune_req_ready;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = APPLY;
            end
            APPLY: begin
                state_nxt = (skip_q[0] || PRE_ZERO) ? LOCK_WAIT : PRELOCK;
            end
            PRELOCK: begin
                if (cnt == PRE_LAST) state_nxt = LOCK_WAIT;
            end
            LOCK_WAIT: begin
                // Lock (or the lock-check skip) wins over an expiring timeout.
                if (skip_q[1] || lock_s) begin
                    if (skip_q[2] || POST_ZERO) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = POSTLOCK;
                    end
                end else if (cnt == TO_LAST) begin
                    state_nxt = IDLE;
                    to_nxt    = 1'b1;
                end
            end
            POSTLOCK: begin
                // Lock is not looked at here, so a drop during settle is ignored.
                if (cnt == POST_LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state          <= IDLE;
            lock_sync      <= '0;
            skip_q         <= '0;
            cnt            <= '0;
            Tune_req_ready <= 1'b0;
            Ad9361_control <= '0;
            Tune_done      <= 1'b0;
            Tune_timeout   <= 1'b0;
            Busy           <= 1'b0;
            Timeout_count  <= '0;
        end else begin
            state     <= state_nxt;
            lock_sync <= {lock_sync[0], Ad9361_status[1]};

            // Cleared on every transition so each phase starts from zero.
            if (state_nxt != state || state_nxt == IDLE) cnt <= '0;
            else                                         cnt <= cnt + 1'b1;

            if (accept) begin
                skip_q         <= Tune_req_skip;
                Ad9361_control <= {1'b1, Tune_req_profile};
            end

            Tune_req_ready <= (state_nxt == IDLE);
            Busy           <= (state_nxt != IDLE);
            Tune_done      <= done_nxt;
            Tune_timeout   <= to_nxt;
            if (to_nxt && Timeout_count != 16'hFFFF)
                Timeout_count <= Timeout_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_esm_tune_sequencer.sv
// Bench for esm_tune_sequencer. Every transaction's outcome (end cycle,
// done vs. timeout) is predicted from the phase lengths and the lock
// waveform the bench itself generates; the DUT is then checked every cycle.
module tb_esm_tune_sequencer;

    localparam int PRE  = 8;
    localparam int POST = 10;
    localparam int TO   = 20;

    logic        Clk;
    logic        Rst;
    logic        Tune_req_valid;
    logic        Tune_req_ready;
    logic [2:0]  Tune_req_profile;
    logic [2:0]  Tune_req_skip;
    logic [3:0]  Ad9361_control;
    logic [7:0]  Ad9361_status;
    logic        Tune_done;
    logic        Tune_timeout;
    logic        Busy;
    logic [15:0] Timeout_count;

    esm_tune_sequencer #(
        .PLL_PRE_LOCK_DELAY_CYCLES (PRE),
        .PLL_POST_LOCK_DELAY_CYCLES(POST),
        .LOCK_TIMEOUT_CYCLES       (TO)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Tune_req_valid  (Tune_req_valid),
        .Tune_req_ready  (Tune_req_ready),
        .Tune_req_profile(Tune_req_profile),
        .Tune_req_skip   (Tune_req_skip),
        .Ad9361_control  (Ad9361_control),
        .Ad9361_status   (Ad9361_status),
        .Tune_done       (Tune_done),
        .Tune_timeout    (Tune_timeout),
        .Busy            (Busy),
        .Timeout_count   (Timeout_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    // Current transaction's lock waveform description.
    int txn_a, txn_d, g_lo, g_hi;
    int exp_tocnt = 0;
    logic [2:0] pend_prof = 3'd0;
    logic [2:0] pend_skip = 3'd0;

    // Monitors for the held-valid test.
    int   acc_cnt = 0;
    int   ctl_chg = 0;
    logic [3:0] last_ctl = 4'd0;
    always @(negedge Clk) begin
        if (Tune_req_valid && Tune_req_ready) acc_cnt++;
        if (Ad9361_control != last_ctl) ctl_chg++;
        last_ctl = Ad9361_control;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cur, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cur++;
    endtask

    task automatic drive_status(input bit l);
        logic [7:0] r;
        r = 8'($urandom);
        r[1] = l;
        Ad9361_status = r;
    endtask

    // Raw lock pin level the bench drives in cycle t.
    function automatic bit lock_at(input int t);
        if (txn_d < 0) return 1'b0;
        if (t >= g_lo && t <= g_hi) return 1'b0;
        return (t >= txn_a + 1 + txn_d);
    endfunction

    // d < 0: lock never rises. chained: the accept cycle is the current one
    // (the previous transaction's completion cycle, valid held high).
    task automatic run_txn(input logic [2:0] prof, input logic [2:0] skp, input int d,
                           input bit glitch, input bit chained, input bit hold);
        int  lw_start, lw_end, endc;
        bit  to;
        txn_d = d;
        g_lo  = -1000;
        g_hi  = -1000;
        if (!chained) begin
            tick();
            Tune_req_valid   = 1'b1;
            Tune_req_profile = prof;
            Tune_req_skip    = skp;
            txn_a = cur;
            drive_status(lock_at(cur));
            @(negedge Clk);
            chk("accept_ready", 32'(Tune_req_ready), 32'd1);
        end else begin
            txn_a = cur;
        end

        // Reference: phase arithmetic, sync lock seen two cycles after the pin.
        to       = 1'b0;
        lw_end   = 0;
        lw_start = txn_a + 2 + ((skp[0] || PRE == 0) ? 0 : PRE);
        if (skp[1]) begin
            lw_end = lw_start;
        end else begin
            to = 1'b1;
            for (int t = lw_start; t < lw_start + TO; t++) begin
                if (lock_at(t - 2)) begin
                    lw_end = t;
                    to     = 1'b0;
                    break;
                end
            end
        end
        if (to) endc = lw_start + TO;
        else    endc = lw_end + 1 + (skp[2] ? 0 : POST);
        if (glitch && !to) begin
            g_lo = lw_end + 1;
            g_hi = lw_end + 3;
        end

        for (int t = txn_a + 1; t <= endc; t++) begin
            tick();
            if (t == endc) begin
                Tune_req_valid   = hold;
                Tune_req_profile = pend_prof;
                Tune_req_skip    = pend_skip;
                drive_status(1'b0);
            end else begin
                // Requests while busy must be ignored.
                Tune_req_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
                if (!hold) begin
                    Tune_req_profile = 3'($urandom);
                    Tune_req_skip    = 3'($urandom);
                end
                drive_status(lock_at(t));
            end
            @(negedge Clk);
            chk("busy",    32'(Busy),           32'(t < endc));
            chk("done",    32'(Tune_done),      32'(t == endc && !to));
            chk("timeout", 32'(Tune_timeout),   32'(t == endc && to));
            chk("ready",   32'(Tune_req_ready), 32'(t == endc));
            chk("control", 32'(Ad9361_control), 32'({1'b1, prof}));
        end
        if (to && exp_tocnt < 16'hFFFF) exp_tocnt++;
        chk("timeout_count", 32'(Timeout_count), 32'(exp_tocnt));
    endtask

    initial begin
        int a0, c0;
        Rst              = 1'b1;
        Tune_req_valid   = 1'b0;
        Tune_req_profile = 3'd0;
        Tune_req_skip    = 3'd0;
        Ad9361_status    = 8'd0;

        // Reset state
        repeat (3) tick();
        @(negedge Clk);
        chk("rst_ready",   32'(Tune_req_ready), 32'd0);
        chk("rst_control", 32'(Ad9361_control), 32'd0);
        chk("rst_busy",    32'(Busy),           32'd0);
        chk("rst_done",    32'(Tune_done),      32'd0);
        chk("rst_to",      32'(Tune_timeout),   32'd0);
        chk("rst_tocnt",   32'(Timeout_count),  32'd0);
        tick();
        Rst = 1'b0;
        @(negedge Clk);
        chk("rel_ready0", 32'(Tune_req_ready), 32'd0);
        tick();
        @(negedge Clk);
        chk("rel_ready1", 32'(Tune_req_ready), 32'd1);

        // Nominal: profile 5, lock 6 cycles after control change
        run_txn(3'd5, 3'b000, 6, 1'b0, 1'b0, 1'b0);
        // All skips, same profile again, lock never seen
        run_txn(3'd5, 3'b111, -1, 1'b0, 1'b0, 1'b0);
        // Lock held low -> timeout
        run_txn(3'd2, 3'b000, -1, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge Clk);
        chk("ready_after_to", 32'(Tune_req_ready), 32'd1);
        // Lock glitch during POSTLOCK
        run_txn(3'd6, 3'b000, 3, 1'b1, 1'b0, 1'b0);

        // Valid held continuously across three requests
        a0 = acc_cnt;
        c0 = ctl_chg;
        pend_prof = 3'd2; pend_skip = 3'b001;
        run_txn(3'd1, 3'b000, 2, 1'b0, 1'b0, 1'b1);
        pend_prof = 3'd3; pend_skip = 3'b100;
        run_txn(3'd2, 3'b001, 4, 1'b0, 1'b1, 1'b1);
        pend_prof = 3'd0; pend_skip = 3'b000;
        run_txn(3'd3, 3'b100, 1, 1'b0, 1'b1, 1'b0);
        tick();
        @(negedge Clk);
        chk("held_accepts",  32'(acc_cnt - a0), 32'd3);
        chk("held_ctl_chgs", 32'(ctl_chg - c0), 32'd3);

        // Reset pulsed during PRELOCK
        tick();
        Tune_req_valid = 1'b1; Tune_req_profile = 3'd4; Tune_req_skip = 3'b000;
        drive_status(1'b0);
        tick(); Tune_req_valid = 1'b0;
        tick();
        tick(); Rst = 1'b1;
        @(negedge Clk);
        chk("prelock_busy", 32'(Busy), 32'd1);
        tick();
        @(negedge Clk);
        chk("mid_rst_busy",    32'(Busy),           32'd0);
        chk("mid_rst_ready",   32'(Tune_req_ready), 32'd0);
        chk("mid_rst_control", 32'(Ad9361_control), 32'd0);
        chk("mid_rst_done",    32'(Tune_done),      32'd0);
        chk("mid_rst_to",      32'(Tune_timeout),   32'd0);
        chk("mid_rst_tocnt",   32'(Timeout_count),  32'd0);
        exp_tocnt = 0;
        tick(); Rst = 1'b0;
        @(negedge Clk);
        chk("post_rst_ready0", 32'(Tune_req_ready), 32'd0);
        chk("post_rst_done",   32'(Tune_done),      32'd0);
        tick();
        @(negedge Clk);
        chk("post_rst_ready1", 32'(Tune_req_ready), 32'd1);
        chk("post_rst_to",     32'(Tune_timeout),   32'd0);
        run_txn(3'd4, 3'b000, 5, 1'b0, 1'b0, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 30; n++) begin
            int  d;
            bit  g;
            d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 30));
            g = 1'($urandom_range(0, 1));
            run_txn(3'($urandom), 3'($urandom), d, g, 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                Tune_req_valid = 1'b0;
                drive_status(1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
